// File: rtl/ascon_pkg.sv
// Shared ASCON definitions: sequencer state encoding, permutation round
// counts and the per-round constant function used by the constant generator.
package ascon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rseq_state_e;

  localparam int ASCON_PA_ROUNDS = 12;
  localparam int ASCON_PB_ROUNDS = 6;

  // Round constant for absolute round index i: high nibble is the
  // complement-to-15 of the index, low nibble is the index itself.
  function automatic logic [7:0] ascon_rc(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

endpackage

// File: rtl/ascon_rc_gen.sv
// Combinational round-constant generator for one unrolled lane. Outputs
// zero while the lane is disabled so the bus is quiet outside a permutation.
module ascon_rc_gen
  import ascon_pkg::*;
(
  input  logic [3:0] idx,
  input  logic       en,
  output logic [7:0] rc
);

  // Constant for this lane's absolute round index, gated by enable
  always_comb begin
    rc = en ? ascon_rc(idx) : 8'h00;
  end

endmodule

// File: rtl/ascon_round_sequencer.sv
// ASCON round sequencer: accepts a permutation request with a round count,
// walks the absolute round index from MAX_ROUNDS-nrounds up to MAX_ROUNDS-1
// in steps of UNROLL, and presents UNROLL round constants per clock.
// Optional feature: define ASCON_RSEQ_ABORT_EN to let `abort` cancel a
// running permutation (back to IDLE, no done pulse); otherwise `abort` is
// accepted on the port but has no effect.
module ascon_round_sequencer
  import ascon_pkg::*;
#(
  parameter int MAX_ROUNDS = ASCON_PA_ROUNDS,
  parameter int UNROLL     = 1,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IDX_W-1:0]      nrounds,
  input  logic                  abort,
  output logic                  busy,
  output logic [IDX_W-1:0]      round_idx,
  output logic [8*UNROLL-1:0]   rc_bus,
  output logic                  first_round,
  output logic                  last_round,
  output logic                  done,
  output logic                  err
);

  // One extra bit so index + step comparisons never wrap
  localparam int             CW    = IDX_W + 1;
  localparam logic [CW-1:0]  MAX_C = CW'(MAX_ROUNDS);
  localparam logic [CW-1:0]  UNR_C = CW'(UNROLL);

  rseq_state_e        state_q, state_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   round_idx_q, round_idx_d;
  logic               first_round_q, first_round_d;
  logic               last_round_q, last_round_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [CW-1:0]      nr_ext;
  logic               nr_legal;
  logic [CW-1:0]      load_idx;
  logic [CW-1:0]      step_idx;
  logic               req_seen;
  logic               accept;
  logic               abort_run;

  // Request qualification and index arithmetic shared by both comb processes
  always_comb begin
    nr_ext   = {1'b0, nrounds};
    nr_legal = (nr_ext != '0) && (nr_ext <= MAX_C) && ((nr_ext % UNR_C) == '0);
    load_idx = MAX_C - nr_ext;
    step_idx = {1'b0, round_idx_q} + UNR_C;
    req_seen = start && ((state_q == IDLE) || (state_q == DONE));
    accept   = req_seen && nr_legal;
  end

`ifdef ASCON_RSEQ_ABORT_EN
  // Cancellation only has meaning while a permutation is running
  always_comb begin
    abort_run = abort && (state_q == RUN);
  end
`else
  logic unused_abort;
  assign unused_abort = abort;
  // Cancellation disabled in this build
  always_comb begin
    abort_run = 1'b0;
  end
`endif

  // State and registered outputs; reset returns everything to idle zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      round_idx_q   <= '0;
      first_round_q <= 1'b0;
      last_round_q  <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      round_idx_q   <= round_idx_d;
      first_round_q <= first_round_d;
      last_round_q  <= last_round_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  // Next-state selection: abort beats last_round, DONE can chain into RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (abort_run)         state_d = IDLE;
        else if (last_round_q) state_d = DONE;
      end
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next registered outputs: load on accept, step while running, zero otherwise
  always_comb begin
    busy_d        = 1'b0;
    round_idx_d   = '0;
    first_round_d = 1'b0;
    last_round_d  = 1'b0;
    done_d        = (state_q == RUN) && (state_d == DONE);
    err_d         = req_seen && !nr_legal;
    if (accept) begin
      busy_d        = 1'b1;
      round_idx_d   = load_idx[IDX_W-1:0];
      first_round_d = 1'b1;
      last_round_d  = ((load_idx + UNR_C) == MAX_C);
    end else if (state_d == RUN) begin
      busy_d        = 1'b1;
      round_idx_d   = step_idx[IDX_W-1:0];
      last_round_d  = ((step_idx + UNR_C) == MAX_C);
    end
  end

  assign busy        = busy_q;
  assign round_idx   = round_idx_q;
  assign first_round = first_round_q;
  assign last_round  = last_round_q;
  assign done        = done_q;
  assign err         = err_q;

  // One constant generator per unrolled lane, lane k covers round_idx + k
  for (genvar k = 0; k < UNROLL; k++) begin : g_lane
    logic [IDX_W-1:0] lane_idx;
    assign lane_idx = round_idx_q + IDX_W'(k);
    ascon_rc_gen u_rc (
      .idx (lane_idx[3:0]),
      .en  (busy_q),
      .rc  (rc_bus[8*k +: 8])
    );
  end

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Bench for ascon_round_sequencer: two instances (UNROLL=1 and UNROLL=2)
// share one stimulus stream; a transaction-level model queues the expected
// per-cycle outputs and a negedge monitor compares what each DUT presents.
module tb_ascon_round_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  nrounds = 4'd0;
  logic        abort = 1'b0;

  logic        busy1, first1, last1, done1, err1;
  logic [3:0]  idx1;
  logic [7:0]  rc1;
  logic        busy2, first2, last2, done2, err2;
  logic [3:0]  idx2;
  logic [15:0] rc2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit fin_req = 1'b0;

  typedef struct {
    int          cyc;
    logic        busy;
    logic [3:0]  idx;
    logic [15:0] rc;
    logic        first;
    logic        last;
    logic        done;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   run_start[2] = '{1, 1};
  int   run_end[2]   = '{0, 0};

  ascon_round_sequencer #(.MAX_ROUNDS(12), .UNROLL(1), .IDX_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .nrounds(nrounds), .abort(abort),
    .busy(busy1), .round_idx(idx1), .rc_bus(rc1), .first_round(first1),
    .last_round(last1), .done(done1), .err(err1)
  );

  ascon_round_sequencer #(.MAX_ROUNDS(12), .UNROLL(2), .IDX_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start), .nrounds(nrounds), .abort(abort),
    .busy(busy2), .round_idx(idx2), .rc_bus(rc2), .first_round(first2),
    .last_round(last2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qfront_cyc(input int d);
    return (d == 0) ? q0[0].cyc : q1[0].cyc;
  endfunction

  task automatic qpop(input int d, output exp_t e);
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
  endtask

  task automatic qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Drop every expectation that would fall after cycle c
  task automatic flush_after(input int d, input int c);
    if (d == 0) begin
      while (q0.size() > 0 && q0[q0.size()-1].cyc > c) void'(q0.pop_back());
    end else begin
      while (q1.size() > 0 && q1[q1.size()-1].cyc > c) void'(q1.pop_back());
    end
  endtask

  // Reference behaviour for the inputs driven during cycle c (sampled at the
  // end of c): a legal request seen outside a run yields S=n/u beats at
  // c+1..c+S walking index 12-n upward by u, then a done cycle at c+S+1.
  task automatic model(input int d, input int u, input int c);
    int   n, s, base, i;
    exp_t e;
    n = int'(nrounds);
    if (rst) begin
      flush_after(d, c);
      run_start[d] = c + 1;
      run_end[d]   = c;
      return;
    end
`ifdef ASCON_RSEQ_ABORT_EN
    if (abort && c >= run_start[d] && c <= run_end[d]) begin
      flush_after(d, c);
      run_end[d] = c;
    end
`endif
    if (start && c > run_end[d]) begin
      if (n >= 1 && n <= 12 && (n % u) == 0) begin
        s    = n / u;
        base = 12 - n;
        for (int k = 0; k < s; k++) begin
          e = '{default: '0};
          e.cyc   = c + 1 + k;
          e.busy  = 1'b1;
          e.idx   = 4'(base + k * u);
          e.first = (k == 0);
          e.last  = (k == s - 1);
          for (int j = 0; j < u; j++) begin
            i = base + k * u + j;
            e.rc = e.rc | (16'(((15 - i) * 16) + i) << (8 * j));
          end
          qpush(d, e);
        end
        e = '{default: '0};
        e.cyc  = c + s + 1;
        e.done = 1'b1;
        qpush(d, e);
        run_start[d] = c + 1;
        run_end[d]   = c + s;
      end else begin
        e = '{default: '0};
        e.cyc = c + 1;
        e.err = 1'b1;
        qpush(d, e);
      end
    end
  endtask

  // Compare one DUT's full output vector against what is due this cycle
  task automatic check_dut(input int d, input logic [24:0] act);
    exp_t        e;
    logic [24:0] expv;
    while (qsize(d) > 0 && qfront_cyc(d) < cyc) begin
      qpop(d, e);
      checks++;
      errors++;
      $display("FAIL overdue dut%0d cyc %0d: event due at cyc %0d never compared", d, cyc, e.cyc);
    end
    e = '{default: '0};
    e.cyc = cyc;
    if (qsize(d) > 0 && qfront_cyc(d) == cyc) qpop(d, e);
    expv = {e.busy, e.idx, e.rc, e.first, e.last, e.done, e.err};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL outputs dut%0d cyc %0d {busy,idx,rc,first,last,done,err} actual %h required %h",
               d, cyc, act, expv);
    end
  endtask

  // Monitor: every cycle both DUTs are checked; final drain check ends the run
  always @(negedge clk) begin
    if (mon_en) begin
      check_dut(0, {busy1, idx1, 8'h00, rc1, first1, last1, done1, err1});
      check_dut(1, {busy2, idx2, rc2, first2, last2, done2, err2});
      if (fin_req) begin
        for (int d = 0; d < 2; d++) begin
          checks++;
          if (qsize(d) != 0) begin
            errors++;
            $display("FAIL drain dut%0d pending %0d required 0", d, qsize(d));
          end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  task automatic step(input logic r, input logic s, input int n, input logic a);
    @(posedge clk);
    #1;
    rst     = r;
    start   = s;
    nrounds = 4'(n);
    abort   = a;
    model(0, 1, cyc);
    model(1, 2, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    // reset held through cycles 0..1, monitor live from the first reset result
    step(1'b1, 1'b0, 0, 1'b0);
    mon_en = 1'b1;
    idle(2);
    // p^a, p^b=6, p^b=8
    step(1'b0, 1'b1, 12, 1'b0); idle(15);
    step(1'b0, 1'b1, 6, 1'b0);  idle(9);
    step(1'b0, 1'b1, 8, 1'b0);  idle(11);
    // 7 is legal for UNROLL=1 only; 0 and 13 are illegal everywhere
    step(1'b0, 1'b1, 7, 1'b0);  idle(10);
    step(1'b0, 1'b1, 0, 1'b0);  idle(2);
    step(1'b0, 1'b1, 13, 1'b0); idle(2);
    // start held high: chains through done cycles, ignored during RUN
    repeat (24) step(1'b0, 1'b1, 6, 1'b0);
    idle(10);
    // illegal starts while running are ignored without err
    step(1'b0, 1'b1, 12, 1'b0);
    repeat (4) step(1'b0, 1'b1, 0, 1'b0);
    idle(12);
    // reset in the middle of a 12-round call
    step(1'b0, 1'b1, 12, 1'b0); idle(4);
    step(1'b1, 1'b0, 0, 1'b0);  idle(4);
    // abort in the middle of a 12-round call
    step(1'b0, 1'b1, 12, 1'b0); idle(4);
    step(1'b0, 1'b0, 0, 1'b1);  idle(14);
    // reset and start together: reset wins
    step(1'b1, 1'b1, 12, 1'b0); idle(3);
    // randomized traffic
    repeat (500) begin
      step(($urandom % 60) == 0, ($urandom % 4) == 0,
           int'($urandom_range(0, 15)), ($urandom % 12) == 0);
    end
    idle(20);
    fin_req = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL finish monitor did not close the run");
    $fatal(1);
  end

endmodule
